cache_sram: RTL and testbench

- Single-port, synchronous-read, byte-enabled memory macro model used by the non-blocking L1 data cache.
- Used for the data array, the tag array and the valid/dirty array.
- One request per cycle; reads return one cycle later.
- Asynchronous reset clears all contents, so valid/dirty bits start at zero without a separate init sweep.

---
 rtl/cache_sram.sv | 90 +++++++++
 tb/tb_cache_sram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sram.sv
// Single-port, synchronous-read, byte-enabled flop-array memory for the L1 data cache.
// Async reset clears all contents, so valid/dirty arrays come up zero without an init sweep.
module cache_sram #(
    parameter int  DATA_WIDTH = 64,
    parameter int  USER_WIDTH = 1,
    parameter int  BYTE_WIDTH = 8,
    parameter int  NUM_WORDS  = 1024,
    localparam int AW         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int NB         = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [USER_WIDTH-1:0] wuser_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NB-1:0]         be_i,
    output logic [USER_WIDTH-1:0] ruser_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam logic [AW:0] DEPTH = NUM_WORDS[AW:0];

    // Expand lane enables to a per-bit mask; the last lane may be narrower.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NB-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            m[b] = be[b / BYTE_WIDTH];
        end
        return m;
    endfunction

    logic                  in_range;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wmask;

    // Depths that are not a power of two leave a hole at the top of the address space.
    assign in_range = ({1'b0, addr_i} < DEPTH);
    assign wr_en    = req_i & we_i & in_range;
    assign rd_en    = req_i & ~we_i;
    assign wmask    = lane_mask(be_i);

    for (genvar g = 0; g < NB; g++) begin : g_lane
        localparam int LO = g * BYTE_WIDTH;
        localparam int LW = (DATA_WIDTH - LO < BYTE_WIDTH) ? (DATA_WIDTH - LO) : BYTE_WIDTH;

        logic [LW-1:0] lane_mem [NUM_WORDS];
        logic [LW-1:0] lane_q;
        logic [LW-1:0] lane_m;

        assign lane_m = wmask[LO +: LW];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    lane_mem[w] <= '0;
                end
                lane_q <= '0;
            end else if (wr_en) begin
                lane_mem[addr_i] <= (lane_mem[addr_i] & ~lane_m) | (wdata_i[LO +: LW] & lane_m);
            end else if (rd_en) begin
                lane_q <= in_range ? lane_mem[addr_i] : '0;
            end
        end

        assign rdata_o[LO +: LW] = lane_q;
    end

    logic [USER_WIDTH-1:0] user_mem [NUM_WORDS];

    // The user field follows the word: stored whenever any lane is written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                user_mem[w] <= '0;
            end
            ruser_o <= '0;
        end else if (wr_en) begin
            if (|be_i) begin
                user_mem[addr_i] <= wuser_i;
            end
        end else if (rd_en) begin
            ruser_o <= in_range ? user_mem[addr_i] : '0;
        end
    end

endmodule

// File: tb/tb_cache_sram.sv
// Bench for cache_sram: three configurations (64b data, 16b valid/dirty bits,
// 12b data with a narrow last lane and a 12-word depth) against an array model.
module tb_cache_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_d, req_v, req_n, we;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [15:0] be;
    logic [1:0]  wuser;

    logic [63:0] rd_d;
    logic [0:0]  ru_d;
    logic [15:0] rd_v;
    logic [0:0]  ru_v;
    logic [11:0] rd_n;
    logic [1:0]  ru_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_sram #(.DATA_WIDTH(64), .USER_WIDTH(1), .BYTE_WIDTH(8), .NUM_WORDS(1024)) u_d (
        .clk_i(clk), .rst_i(rst), .req_i(req_d), .we_i(we), .addr_i(addr),
        .wuser_i(wuser[0:0]), .wdata_i(wdata), .be_i(be[7:0]),
        .ruser_o(ru_d), .rdata_o(rd_d));

    cache_sram #(.DATA_WIDTH(16), .USER_WIDTH(1), .BYTE_WIDTH(1), .NUM_WORDS(16)) u_v (
        .clk_i(clk), .rst_i(rst), .req_i(req_v), .we_i(we), .addr_i(addr[3:0]),
        .wuser_i(wuser[0:0]), .wdata_i(wdata[15:0]), .be_i(be),
        .ruser_o(ru_v), .rdata_o(rd_v));

    cache_sram #(.DATA_WIDTH(12), .USER_WIDTH(2), .BYTE_WIDTH(8), .NUM_WORDS(12)) u_n (
        .clk_i(clk), .rst_i(rst), .req_i(req_n), .we_i(we), .addr_i(addr[3:0]),
        .wuser_i(wuser), .wdata_i(wdata[11:0]), .be_i(be[1:0]),
        .ruser_o(ru_n), .rdata_o(rd_n));

    // Reference model: one word array per instance, plus the expected output registers.
    localparam int DWS [3] = '{64, 16, 12};
    localparam int BWS [3] = '{8, 1, 8};
    localparam int NBS [3] = '{8, 16, 2};
    localparam int NWS [3] = '{1024, 16, 12};
    localparam int UMS [3] = '{1, 1, 3};

    logic [63:0] mm [3][1024];
    logic [1:0]  mu [3][1024];
    logic [63:0] exp_rd [3];
    logic [1:0]  exp_ru [3];

    typedef struct {
        bit          rq;
        bit          w;
        int          a;
        logic [63:0] d;
        logic [15:0] b;
        logic [1:0]  u;
        logic [63:0] er;
        logic [1:0]  eu;
    } vec_t;

    vec_t tbl [$];

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [15:0] b, input int dw, input int bw);
        logic [63:0] r = old;
        for (int k = 0; k * bw < dw; k++) begin
            if (b[k]) begin
                for (int i = k * bw; i < (k + 1) * bw && i < dw; i++) r[i] = d[i];
            end
        end
        return r;
    endfunction

    task automatic clr_model();
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 1024; w++) begin
                mm[n][w] = '0;
                mu[n][w] = '0;
            end
            exp_rd[n] = '0;
            exp_ru[n] = '0;
        end
    endtask

    task automatic op(input int inst, input bit rq, input bit w, input int a,
                      input logic [63:0] d, input logic [15:0] b, input logic [1:0] u);
        logic [15:0] be_eff;
        req_d = rq && inst == 0;
        req_v = rq && inst == 1;
        req_n = rq && inst == 2;
        we    = w;
        addr  = a[9:0];
        wdata = d;
        be    = b;
        wuser = u;
        @(posedge clk);
        #1;
        req_d = 1'b0;
        req_v = 1'b0;
        req_n = 1'b0;
        be_eff = b & 16'((32'd1 << NBS[inst]) - 1);
        if (rq) begin
            if (w) begin
                if (a < NWS[inst] && be_eff != 0) begin
                    mm[inst][a] = merge(mm[inst][a], d, be_eff, DWS[inst], BWS[inst]);
                    mu[inst][a] = u & 2'(UMS[inst]);
                end
            end else begin
                exp_rd[inst] = (a < NWS[inst]) ? mm[inst][a] : '0;
                exp_ru[inst] = (a < NWS[inst]) ? mu[inst][a] : '0;
            end
        end
    endtask

    task automatic check_out(input string nm, input int inst,
                             input logic [63:0] er, input logic [1:0] eu);
        logic [63:0] ard;
        logic [1:0]  aru;
        ard = (inst == 0) ? rd_d : (inst == 1) ? {48'b0, rd_v} : {52'b0, rd_n};
        aru = (inst == 0) ? {1'b0, ru_d} : (inst == 1) ? {1'b0, ru_v} : ru_n;
        total++;
        if (ard !== er) begin
            bad++;
            $display("FAIL %s rdata got=%h want=%h", nm, ard, er);
        end
        total++;
        if (aru !== eu) begin
            bad++;
            $display("FAIL %s ruser got=%h want=%h", nm, aru, eu);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clr_model();
        rst = 1'b1;
        req_d = 1'b0; req_v = 1'b0; req_n = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; be = '0; wuser = '0;
        #2;
        check_out("rst_d", 0, 64'h0, 2'h0);
        check_out("rst_v", 1, 64'h0, 2'h0);
        check_out("rst_n", 2, 64'h0, 2'h0);
        // A write while reset is held must be overridden.
        req_d = 1'b1; we = 1'b1; addr = 10'd5; wdata = 64'hFFFF_FFFF_FFFF_FFFF; be = 16'hFF; wuser = 2'b1;
        @(posedge clk);
        #1;
        req_d = 1'b0;
        check_out("rst_hold", 0, 64'h0, 2'h0);
        @(negedge clk);
        rst = 1'b0;
        op(0, 1, 0, 5, 64'h0, 16'h0, 2'h0);
        check_out("rst_override", 0, 64'h0, 2'h0);

        tbl.push_back('{1, 1, 7,    64'h1111_1111_1111_1111, 16'hFF, 2'd1, 64'h0, 2'd0});
        tbl.push_back('{1, 1, 7,    64'hAAAA_BBBB_CCCC_DDDD, 16'h0F, 2'd0, 64'h0, 2'd0});
        tbl.push_back('{1, 0, 7,    64'h0, 16'h00, 2'd0, 64'h1111_1111_CCCC_DDDD, 2'd0});
        tbl.push_back('{1, 1, 3,    64'h5, 16'hFF, 2'd1, 64'h1111_1111_CCCC_DDDD, 2'd0});
        tbl.push_back('{1, 0, 3,    64'h0, 16'h00, 2'd0, 64'h5, 2'd1});
        for (int i = 0; i < 4; i++) tbl.push_back('{0, 0, 3, 64'h0, 16'h00, 2'd0, 64'h5, 2'd1});
        tbl.push_back('{1, 1, 3,    64'h0123_4567_89AB_CDEF, 16'hFF, 2'd0, 64'h5, 2'd1});
        tbl.push_back('{1, 0, 3,    64'h0, 16'hFF, 2'd0, 64'h0123_4567_89AB_CDEF, 2'd0});
        tbl.push_back('{1, 1, 1023, 64'hFEDC_BA98_7654_3210, 16'h80, 2'd1, 64'h0123_4567_89AB_CDEF, 2'd0});
        tbl.push_back('{1, 0, 1023, 64'h0, 16'h00, 2'd0, 64'hFE00_0000_0000_0000, 2'd1});
        tbl.push_back('{1, 0, 7,    64'h0, 16'h00, 2'd0, 64'h1111_1111_CCCC_DDDD, 2'd0});
        foreach (tbl[i]) begin
            op(0, tbl[i].rq, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].u);
            check_out($sformatf("vec%0d", i), 0, tbl[i].er, tbl[i].eu);
        end

        // Asynchronous reset mid-cycle clears outputs before any clock edge.
        op(0, 1, 1, 5, 64'hDEAD_BEEF_0123_4567, 16'hFF, 2'd1);
        op(0, 1, 0, 5, 64'h0, 16'h0, 2'd0);
        check_out("pre_rst", 0, 64'hDEAD_BEEF_0123_4567, 2'd1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 0, 64'h0, 2'd0);
        @(posedge clk);
        #1;
        check_out("rst_stay", 0, 64'h0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        clr_model();
        op(0, 1, 0, 5, 64'h0, 16'h0, 2'd0);
        check_out("post_rst", 0, 64'h0, 2'd0);

        // Valid/dirty configuration: one bit per lane.
        op(1, 1, 1, 2, 64'hFFFF, 16'h0004, 2'd1);
        op(1, 1, 0, 2, 64'h0, 16'h0, 2'd0);
        check_out("vd_bit", 1, 64'h0004, 2'd1);
        op(1, 1, 1, 2, 64'h0, 16'h0000, 2'd0);
        op(1, 1, 0, 2, 64'h0, 16'h0, 2'd0);
        check_out("vd_be0", 1, 64'h0004, 2'd1);

        // 12-word depth with a 4-bit top lane.
        op(2, 1, 1, 11, 64'hFFF, 16'h1, 2'd3);
        op(2, 1, 0, 11, 64'h0, 16'h0, 2'd0);
        check_out("np_lo", 2, 64'h0FF, 2'd3);
        op(2, 1, 1, 11, 64'hABC, 16'h2, 2'd2);
        op(2, 1, 0, 11, 64'h0, 16'h0, 2'd0);
        check_out("np_narrow", 2, 64'hAFF, 2'd2);
        op(2, 1, 1, 13, 64'h123, 16'h3, 2'd1);
        op(2, 1, 0, 13, 64'h0, 16'h0, 2'd0);
        check_out("np_oor", 2, 64'h0, 2'd0);
        op(2, 1, 0, 1, 64'h0, 16'h0, 2'd0);
        check_out("np_alias", 2, 64'h0, 2'd0);
        op(2, 1, 0, 11, 64'h0, 16'h0, 2'd0);
        check_out("np_keep", 2, 64'hAFF, 2'd2);

        // Alternating random write/read at the ends of the address range.
        for (int i = 0; i < 100; i++) begin
            int a;
            a = ($urandom_range(0, 1) != 0) ? 1023 : 0;
            op(0, 1, (i % 2) == 0, a, {$urandom, $urandom}, 16'($urandom_range(0, 255)),
               2'($urandom_range(0, 1)));
            check_out($sformatf("rnd_d%0d", i), 0, exp_rd[0], exp_ru[0]);
        end
        for (int i = 0; i < 40; i++) begin
            int a;
            a = ($urandom_range(0, 3) == 0) ? 13 : (($urandom_range(0, 1) != 0) ? 11 : 0);
            op(2, 1, (i % 2) == 0, a, 64'($urandom), 16'($urandom_range(0, 3)),
               2'($urandom_range(0, 3)));
            check_out($sformatf("rnd_n%0d", i), 2, exp_rd[2], exp_ru[2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
